// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and the shared RAM port.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  logic              err;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, err, ramREN, ramWEN, ramaddr, ramstore
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, iload, dhit, dload, err, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data-first priority with instruction starvation guard
// and a grant watchdog that aborts unacknowledged accesses.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic CLK,
  input  logic nRST,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT, RESP} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SMAX    = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ABORT_WORD = DATA_W'(32'hBAD1BAD1);

  state_t            r_state, w_next;
  logic [SW-1:0]     r_starve;
  logic [WW-1:0]     r_wd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_store;
  logic [DATA_W-1:0] r_iload, r_dload;
  logic              r_wr, r_dside, r_abort;
  logic              w_dreq, w_starve_sat, w_force_i, w_grant, w_wd_exp;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_dreq       = bus.dREN | bus.dWEN;
    w_starve_sat = (r_starve == SMAX);
    w_force_i    = bus.iREN && w_starve_sat;
    w_grant      = (r_state == IGRANT) || (r_state == DGRANT);
    w_wd_exp     = (r_wd == WD_LAST);
    case (r_state)
      IDLE: begin
        if (w_dreq && !w_force_i) w_next = DGRANT;
        else if (bus.iREN)        w_next = IGRANT;
      end
      IGRANT, DGRANT: if (bus.ram_ready || w_wd_exp) w_next = RESP;
      RESP:           w_next = IDLE;
      default:        w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve <= '0;
      r_wd     <= '0;
      r_addr   <= '0;
      r_store  <= '0;
      r_iload  <= '0;
      r_dload  <= '0;
      r_wr     <= 1'b0;
      r_dside  <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wd    <= '0;
          r_abort <= 1'b0;
          if (w_next == DGRANT) begin
            r_addr  <= bus.daddr;
            r_store <= bus.dstore;
            r_wr    <= bus.dWEN;
            r_dside <= 1'b1;
            if (!bus.iREN)         r_starve <= '0;
            else if (!w_starve_sat) r_starve <= r_starve + 1'b1;
          end else if (w_next == IGRANT) begin
            r_addr   <= bus.iaddr;
            r_wr     <= 1'b0;
            r_dside  <= 1'b0;
            r_starve <= '0;
          end
        end
        IGRANT, DGRANT: begin
          if (bus.ram_ready) begin
            if (r_dside) r_dload <= bus.ramload;
            else         r_iload <= bus.ramload;
          end else if (w_wd_exp) begin
            r_abort <= 1'b1;
            if (r_dside) r_dload <= ABORT_WORD;
            else         r_iload <= ABORT_WORD;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: r_wd <= '0;
      endcase
    end
  end

  // Enables and hit pulses decode straight from state so reset drops them at once.
  assign bus.ramREN   = (r_state == IGRANT) || ((r_state == DGRANT) && !r_wr);
  assign bus.ramWEN   = (r_state == DGRANT) && r_wr;
  assign bus.ramaddr  = r_addr;
  assign bus.ramstore = r_store;
  assign bus.ihit     = (r_state == RESP) && !r_dside;
  assign bus.dhit     = (r_state == RESP) && r_dside;
  assign bus.err      = (r_state == RESP) && r_abort;
  assign bus.iload    = r_iload;
  assign bus.dload    = r_dload;

  logic w_unused;
  assign w_unused = w_grant;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter plus a randomized run against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, SMAX = 4, TMO = 64;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int errors = 0;
  int checks = 0;
  int starve_m = 0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO))
    dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic wait_grant(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 8) begin
      step();
      n++;
      if (bus.ramREN || bus.ramWEN) ok = 1'b1;
    end
  endtask

  task automatic ram_respond(input int k, input logic [DW-1:0] v);
    repeat (k) step();
    bus.ram_ready = 1'b1;
    bus.ramload   = v;
    step();
    bus.ram_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.ihit, bus.dhit, bus.err, bus.ramREN, bus.ramWEN} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want 00000", {bus.ihit, bus.dhit, bus.err, bus.ramREN, bus.ramWEN});
    end
    checks++;
    if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== '0) begin
      errors++; $display("FAIL reset_data: ramaddr=%h ramstore=%h iload=%h dload=%h want 0",
                         bus.ramaddr, bus.ramstore, bus.iload, bus.dload);
    end
  endtask

  task automatic test_ifetch();
    bit ok;
    int ren_cnt;
    bit wen_seen;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    wait_grant(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ifetch_grant: no grant within bound"); end
    checks++;
    if (bus.ramaddr !== 32'h40) begin errors++; $display("FAIL ifetch_addr: got %h want 40", bus.ramaddr); end
    ren_cnt = 0; wen_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.ramREN) ren_cnt++;
      if (bus.ramWEN) wen_seen = 1'b1;
      if (i == 3) begin bus.ram_ready = 1'b1; bus.ramload = 32'h8C220004; end
      step();
    end
    bus.ram_ready = 1'b0;
    checks++;
    if (ren_cnt != 4 || wen_seen) begin
      errors++; $display("FAIL ifetch_enables: ren_cycles=%0d wen_seen=%0d want 4/0", ren_cnt, wen_seen);
    end
    checks++;
    if (!(bus.ihit === 1'b1 && bus.dhit === 1'b0 && bus.err === 1'b0 && bus.iload === 32'h8C220004 && bus.ramREN === 1'b0)) begin
      errors++; $display("FAIL ifetch_hit: ihit=%b dhit=%b err=%b iload=%h want 1/0/0/8c220004", bus.ihit, bus.dhit, bus.err, bus.iload);
    end
    bus.iREN = 1'b0;
    step();
    checks++;
    if (bus.ihit !== 1'b0 || bus.iload !== 32'h8C220004) begin
      errors++; $display("FAIL ifetch_hold: ihit=%b iload=%h want 0/8c220004", bus.ihit, bus.iload);
    end
  endtask

  task automatic test_priority();
    bit ok;
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dREN = 1'b1; bus.daddr = 32'h100;
    wait_grant(ok);
    checks++;
    if (!ok || bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100) begin
      errors++; $display("FAIL prio_dfirst: ok=%0d ramREN=%b ramaddr=%h want 1/1/100", ok, bus.ramREN, bus.ramaddr);
    end
    ram_respond(1, 32'h11223344);
    checks++;
    if (bus.dhit !== 1'b1 || bus.ihit !== 1'b0 || bus.dload !== 32'h11223344) begin
      errors++; $display("FAIL prio_dhit: dhit=%b ihit=%b dload=%h want 1/0/11223344", bus.dhit, bus.ihit, bus.dload);
    end
    bus.dREN = 1'b0;
    step();
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
      errors++; $display("FAIL prio_idle: ramREN=%b ramWEN=%b want 0/0", bus.ramREN, bus.ramWEN);
    end
    step();
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h44) begin
      errors++; $display("FAIL prio_igrant: ramREN=%b ramaddr=%h want 1/44", bus.ramREN, bus.ramaddr);
    end
    ram_respond(0, 32'h55);
    checks++;
    if (bus.ihit !== 1'b1 || bus.iload !== 32'h55) begin
      errors++; $display("FAIL prio_ihit: ihit=%b iload=%h want 1/55", bus.ihit, bus.iload);
    end
    bus.iREN = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    bit ok;
    bit got_i;
    int dcnt;
    bus.iREN = 1'b1; bus.iaddr = 32'h80;
    bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'h1;
    dcnt = 0; got_i = 1'b0;
    for (int n = 0; n < 8 && !got_i; n++) begin
      wait_grant(ok);
      if (!ok) break;
      if (bus.ramWEN) begin
        dcnt++;
        ram_respond(0, 32'h0);
        bus.dWEN = 1'b0;
        step();
        bus.dWEN = 1'b1; bus.daddr = 32'h300 + 32'(n);
      end else begin
        got_i = 1'b1;
      end
    end
    checks++;
    if (!got_i || dcnt != SMAX || bus.ramaddr !== 32'h80) begin
      errors++; $display("FAIL starve_count: data_grants=%0d igrant=%0d ramaddr=%h want %0d/1/80", dcnt, got_i, bus.ramaddr, SMAX);
    end
    ram_respond(0, 32'h77);
    bus.iREN = 1'b0;
    step();
    bus.iREN = 1'b1;
    wait_grant(ok);
    checks++;
    if (!ok || bus.ramWEN !== 1'b1) begin
      errors++; $display("FAIL starve_cleared: ok=%0d ramWEN=%b want 1/1", ok, bus.ramWEN);
    end
    ram_respond(0, 32'h0);
    bus.dWEN = 1'b0; bus.iREN = 1'b0;
    step();
  endtask

  task automatic test_latched_write();
    bit ok;
    bit bad;
    bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
    wait_grant(ok);
    bus.daddr = 32'h999; bus.dstore = 32'h0; bus.dREN = 1'b1;
    bad = !ok;
    for (int i = 0; i < 3; i++) begin
      if (bus.ramaddr !== 32'h200 || bus.ramstore !== 32'hDEADBEEF || bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL latch_write: ramaddr=%h ramstore=%h ramWEN=%b want 200/deadbeef/1", bus.ramaddr, bus.ramstore, bus.ramWEN);
    end
    ram_respond(0, 32'h0);
    checks++;
    if (bus.dhit !== 1'b1 || bus.err !== 1'b0) begin
      errors++; $display("FAIL latch_dhit: dhit=%b err=%b want 1/0", bus.dhit, bus.err);
    end
    bus.dWEN = 1'b0; bus.dREN = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    bus.dREN = 1'b1; bus.daddr = 32'h404;
    wait_grant(ok);
    cnt = ok ? 1 : 0;
    while (ok && cnt < 200) begin
      step();
      if (!bus.ramREN) break;
      cnt++;
    end
    checks++;
    if (cnt != TMO) begin errors++; $display("FAIL timeout_len: grant_cycles=%0d want %0d", cnt, TMO); end
    checks++;
    if (bus.dhit !== 1'b1 || bus.err !== 1'b1 || bus.dload !== 32'hBAD1BAD1) begin
      errors++; $display("FAIL timeout_resp: dhit=%b err=%b dload=%h want 1/1/bad1bad1", bus.dhit, bus.err, bus.dload);
    end
    bus.dREN = 1'b0;
    step();
    checks++;
    if (bus.err !== 1'b0 || bus.dhit !== 1'b0 || bus.ramREN !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: err=%b dhit=%b ramREN=%b want 0/0/0", bus.err, bus.dhit, bus.ramREN);
    end
    bus.dREN = 1'b1; bus.daddr = 32'h408;
    wait_grant(ok);
    ram_respond(2, 32'hA5A5);
    checks++;
    if (!ok || bus.dhit !== 1'b1 || bus.err !== 1'b0 || bus.dload !== 32'hA5A5) begin
      errors++; $display("FAIL timeout_recover: ok=%0d dhit=%b err=%b dload=%h want 1/1/0/a5a5", ok, bus.dhit, bus.err, bus.dload);
    end
    bus.dREN = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    bit ok;
    bit spur;
    bus.dWEN = 1'b1; bus.daddr = 32'h500; bus.dstore = 32'h5;
    wait_grant(ok);
    step();
    nRST = 1'b0;
    #1;
    checks++;
    if (!ok || bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0) begin
      errors++; $display("FAIL rst_drop: ok=%0d ramWEN=%b ramREN=%b want 1/0/0", ok, bus.ramWEN, bus.ramREN);
    end
    bus.dWEN = 1'b0;
    bus.ram_ready = 1'b1;
    step();
    step();
    nRST = 1'b1;
    spur = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.ihit || bus.dhit || bus.err || bus.ramREN || bus.ramWEN) spur = 1'b1;
    end
    bus.ram_ready = 1'b0;
    checks++;
    if (spur || bus.ramaddr !== '0) begin
      errors++; $display("FAIL rst_quiet: spurious=%0d ramaddr=%h want 0/0", spur, bus.ramaddr);
    end
    starve_m = 0;
  endtask

  task automatic test_random();
    bit ok, exp_d, exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_store, val;
    int bad;
    bad = 0;
    for (int r = 0; r < 200; r++) begin
      if (!bus.iREN && $urandom_range(0, 1) == 1) begin bus.iREN = 1'b1; bus.iaddr = $urandom; end
      if (!(bus.dREN || bus.dWEN) && $urandom_range(0, 1) == 1) begin
        bus.dREN = 1'($urandom_range(0, 1)); bus.dWEN = !bus.dREN || ($urandom_range(0, 3) == 0);
        bus.daddr = $urandom; bus.dstore = $urandom;
      end
      if (!bus.iREN && !bus.dREN && !bus.dWEN) begin step(); continue; end
      exp_d     = (bus.dREN || bus.dWEN) && !(bus.iREN && starve_m >= SMAX);
      exp_wr    = exp_d && bus.dWEN;
      exp_addr  = exp_d ? bus.daddr : bus.iaddr;
      exp_store = bus.dstore;
      wait_grant(ok);
      checks++;
      if (!ok || bus.ramWEN !== exp_wr || bus.ramREN !== !exp_wr || bus.ramaddr !== exp_addr ||
          (exp_wr && bus.ramstore !== exp_store)) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_grant[%0d]: ren=%b wen=%b addr=%h want wen=%b addr=%h", r, bus.ramREN, bus.ramWEN, bus.ramaddr, exp_wr, exp_addr);
      end
      val = $urandom;
      ram_respond($urandom_range(0, 4), val);
      checks++;
      if (bus.dhit !== exp_d || bus.ihit !== !exp_d || bus.err !== 1'b0 ||
          (exp_d ? bus.dload : bus.iload) !== val) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_hit[%0d]: ihit=%b dhit=%b err=%b want dhit=%b data=%h", r, bus.ihit, bus.dhit, bus.err, exp_d, val);
      end
      if (exp_d) begin
        starve_m = bus.iREN ? ((starve_m < SMAX) ? starve_m + 1 : SMAX) : 0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0;
      end else begin
        starve_m = 0;
        bus.iREN = 1'b0;
      end
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    step();
  endtask

  initial begin
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ram_ready = 1'b0;
    nRST = 1'b0;
    step();
    step();
    test_reset();
    nRST = 1'b1;
    step();
    test_ifetch();
    test_priority();
    test_starvation();
    test_latched_write();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
